// File: rtl/controle_multiciclo.sv
// Multicycle control unit for the 16-bit datapath: fetch, ROM wait, decode, execute,
// data-memory wait with timeout, and writeback. All outputs are registered (Moore).
module controle_multiciclo #(
    parameter int ROM_LAT    = 1,
    parameter int MD_TIMEOUT = 15,
    parameter int CONT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              botao,
    input  logic              modo_passo,
    input  logic [15:0]       instrucao,
    input  logic              md_pronto,
    output logic              controlePC,
    output logic              Rom_sink_ren,
    output logic              Rom_sink_cen,
    output logic              controlePCcopia,
    output logic [2:0]        BR_Sel_E_SA,
    output logic [2:0]        BR_Sel_SB,
    output logic              BR_Hab_Escrita,
    output logic              MD_Hab_Escrita,
    output logic [11:0]       EXconstante,
    output logic [2:0]        EXcontrole,
    output logic [7:0]        ULA_OP,
    output logic              Controle_Mux1,
    output logic [1:0]        Controle_Mux2,
    output logic              controleMUX_PC,
    output logic              jump_ver_fal,
    output logic [3:0]        condicaoJump,
    output logic [4:0]        atualizaFlag,
    output logic              erro_md,
    output logic [CONT_W-1:0] instr_cont,
    output logic [2:0]        estado_dbg
);
    typedef enum logic [2:0] {
        OCIOSO = 3'd0, BUSCA = 3'd1, ESPERA_ROM = 3'd2, DECODIFICA = 3'd3,
        EXECUTA = 3'd4, MEMORIA = 3'd5, ESCRITA = 3'd6
    } estado_t;

    localparam int CMAX = (ROM_LAT > MD_TIMEOUT) ? ROM_LAT : MD_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    estado_t estado_q, estado_d;
    logic [15:0] ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CONT_W-1:0] cont_q, cont_d;
    logic primeiro_q, primeiro_d, botao_q, botao_d, erro_q, erro_d;
    logic pc_q, pc_d, ren_q, ren_d, copia_q, copia_d, brwe_q, brwe_d, mdwe_q, mdwe_d;
    logic [2:0] sa_q, sa_d, sb_q, sb_d, exctl_q, exctl_d;
    logic [11:0] exc_q, exc_d;
    logic [7:0] op_q, op_d;
    logic m1_q, m1_d, mpc_q, mpc_d, jvf_q, jvf_d;
    logic [1:0] m2_q, m2_d;
    logic [3:0] cj_q, cj_d;
    logic [4:0] af_q, af_d;

    logic [1:0] fmt, j;
    logic [4:0] op5;
    logic is_ld, is_st, is_jal, go_busca, go_escrita, timeout;

    assign fmt    = ir_q[15:14];
    assign j      = ir_q[13:12];
    assign is_ld  = (fmt == 2'b10) && (ir_q[10:6] == 5'b01010);
    assign is_st  = (fmt == 2'b10) && (ir_q[10:6] == 5'b01011);
    assign is_jal = (ir_q[15:11] == 5'b00110);
    assign op5    = (fmt == 2'b10) ? ir_q[10:6] :
                    (fmt == 2'b00 && j == 2'b11) ? 5'b10011 : 5'b00000;

    always_comb begin
        estado_d = estado_q;  ir_d = ir_q;  cnt_d = cnt_q;  cont_d = cont_q;
        primeiro_d = primeiro_q;  botao_d = botao;  erro_d = erro_q;
        pc_d = 1'b0;  ren_d = 1'b0;  copia_d = 1'b0;  brwe_d = 1'b0;  mdwe_d = 1'b0;
        sa_d = sa_q;  sb_d = sb_q;  exc_d = exc_q;  exctl_d = exctl_q;  op_d = op_q;
        m1_d = m1_q;  m2_d = m2_q;  mpc_d = mpc_q;  jvf_d = jvf_q;  cj_d = cj_q;  af_d = af_q;
        go_busca = 1'b0;  go_escrita = 1'b0;  timeout = 1'b0;
        case (estado_q)
            OCIOSO: go_busca = !modo_passo || (botao && !botao_q);
            BUSCA: begin
                estado_d = ESPERA_ROM;
                ren_d    = 1'b1;
                cnt_d    = '0;
            end
            ESPERA_ROM: begin
                if (cnt_q == CW'(ROM_LAT - 1)) begin
                    // Decode straight from the word being latched so fields are valid in DECODIFICA.
                    ir_d = instrucao;  estado_d = DECODIFICA;
                    sa_d = '0;  sb_d = '0;  exc_d = '0;  exctl_d = '0;
                    case (ir_d[15:14])
                        2'b10: begin sa_d = ir_d[5:3]; sb_d = ir_d[2:0]; end
                        2'b01: exc_d = {1'b0, ir_d[10:0]};
                        2'b11: begin
                            sa_d = ir_d[13:11];  exc_d = {4'b0, ir_d[7:0]};
                            exctl_d = ir_d[10] ? 3'b010 : 3'b001;
                        end
                        default: case (ir_d[13:12])
                            2'b10:   begin exc_d = ir_d[11:0]; exctl_d = 3'b100; end
                            2'b11:   begin sb_d = ir_d[2:0]; copia_d = !ir_d[11]; end
                            default: begin exc_d = {4'b0, ir_d[7:0]}; exctl_d = 3'b011; end
                        endcase
                    endcase
                end else begin
                    ren_d = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DECODIFICA: begin
                estado_d = EXECUTA;
                op_d  = {fmt, ir_q[10], op5};
                m1_d  = (fmt != 2'b10);
                af_d  = (fmt == 2'b10 && !is_ld && !is_st) ? ir_q[10:6] : 5'b11111;
                cj_d  = (fmt != 2'b00) ? 4'b1111 : (j[1] ? 4'b1100 : ir_q[11:8]);
                jvf_d = (fmt == 2'b00 && !j[1]) ? ir_q[12] : 1'b0;
                mpc_d = !(fmt == 2'b00 && j != 2'b11);
            end
            EXECUTA: begin
                if (is_ld || is_st) begin
                    estado_d = MEMORIA;  mdwe_d = is_st;  cnt_d = '0;
                end else begin
                    go_escrita = 1'b1;
                end
            end
            MEMORIA: begin
                if (md_pronto) begin
                    go_escrita = 1'b1;
                end else if (cnt_q == CW'(MD_TIMEOUT - 1)) begin
                    go_escrita = 1'b1;  timeout = 1'b1;  erro_d = 1'b1;
                end else begin
                    mdwe_d = is_st;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            ESCRITA: begin
                cont_d = cont_q + CONT_W'(1);
                if (modo_passo) estado_d = OCIOSO;
                else            go_busca = 1'b1;
            end
            default: estado_d = OCIOSO;
        endcase

        if (go_busca) begin
            estado_d = BUSCA;  ren_d = 1'b1;  pc_d = !primeiro_q;  primeiro_d = 1'b0;
        end
        if (go_escrita) begin
            estado_d = ESCRITA;
            sa_d = ir_q[13:11];  cj_d = 4'b1111;  jvf_d = 1'b0;  af_d = 5'b11111;
            m2_d = is_jal ? 2'b10 : (is_ld ? 2'b01 : 2'b00);
            // A timed-out load has no valid data, so it must not reach the register bank.
            brwe_d = !(is_st || (fmt == 2'b00 && !is_jal) || (is_ld && timeout));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;  ir_q <= '0;  cnt_q <= '0;  cont_q <= '0;
            primeiro_q <= 1'b1;  botao_q <= 1'b0;  erro_q <= 1'b0;
            pc_q <= 1'b0;  ren_q <= 1'b0;  copia_q <= 1'b0;  brwe_q <= 1'b0;  mdwe_q <= 1'b0;
            sa_q <= '0;  sb_q <= '0;  exc_q <= '0;  exctl_q <= '0;  op_q <= '0;
            m1_q <= 1'b0;  m2_q <= '0;  mpc_q <= 1'b1;  jvf_q <= 1'b0;
            cj_q <= 4'b1111;  af_q <= 5'b11111;
        end else begin
            estado_q <= estado_d;  ir_q <= ir_d;  cnt_q <= cnt_d;  cont_q <= cont_d;
            primeiro_q <= primeiro_d;  botao_q <= botao_d;  erro_q <= erro_d;
            pc_q <= pc_d;  ren_q <= ren_d;  copia_q <= copia_d;  brwe_q <= brwe_d;  mdwe_q <= mdwe_d;
            sa_q <= sa_d;  sb_q <= sb_d;  exc_q <= exc_d;  exctl_q <= exctl_d;  op_q <= op_d;
            m1_q <= m1_d;  m2_q <= m2_d;  mpc_q <= mpc_d;  jvf_q <= jvf_d;
            cj_q <= cj_d;  af_q <= af_d;
        end
    end

    assign controlePC      = pc_q;
    assign Rom_sink_ren    = ren_q;
    assign Rom_sink_cen    = ren_q;
    assign controlePCcopia = copia_q;
    assign BR_Sel_E_SA     = sa_q;
    assign BR_Sel_SB       = sb_q;
    assign BR_Hab_Escrita  = brwe_q;
    assign MD_Hab_Escrita  = mdwe_q;
    assign EXconstante     = exc_q;
    assign EXcontrole      = exctl_q;
    assign ULA_OP          = op_q;
    assign Controle_Mux1   = m1_q;
    assign Controle_Mux2   = m2_q;
    assign controleMUX_PC  = mpc_q;
    assign jump_ver_fal    = jvf_q;
    assign condicaoJump    = cj_q;
    assign atualizaFlag    = af_q;
    assign erro_md         = erro_q;
    assign instr_cont      = cont_q;
    assign estado_dbg      = estado_q;
endmodule
